wfi_protocol_monitor: RTL and testbench

- Multi-hart, synthesizable successor to the single-hart WFI testbench checker.
- Tracks each hart's retired WFI instruction against its wfi status output and flags four protocol violations: spurious assertion, missing assertion, entry with an interrupt pending, and failure to wake.
- Sits in the testbench/emulation harness beside the core complex.
- Reports errors through registered flags instead of stopping simulation, so it is usable on FPGA/emulation.

---
 rtl/wfi_protocol_monitor.sv | 214 +++++++++++++++++++++
 tb/tb_wfi_protocol_monitor.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wfi_protocol_monitor.sv
// wfi_protocol_monitor
// Multi-hart WFI protocol checker for the emulation harness. Each hart runs a
// small IDLE/ARMED/ASLEEP tracker that compares retired WFI instructions
// against the core's wfi status. Violations are reported on registered ports
// (err_valid pulse, err_code, err_hart, sticky flags), never by stopping time.
// Optional feature: define WFI_PROTOCOL_MONITOR_FATAL_EN to make every error
// pulse print a message and call $fatal in simulation.
module wfi_protocol_monitor #(
    parameter int          NUM_HARTS  = 4,
    parameter int          SKIP_CNT   = 100,
    parameter int          WAKE_CNT   = 64,
    parameter int          CNT_W      = 16,
    parameter logic [31:0] WFI_OPCODE = 32'h10500073,
    localparam int         HART_W     = (NUM_HARTS > 1) ? $clog2(NUM_HARTS) : 1
) (
    input  logic                       clock,
    input  logic                       reset_n,
    input  logic [NUM_HARTS-1:0]       wfi,
    input  logic [NUM_HARTS-1:0]       retire_valid,
    input  logic [32*NUM_HARTS-1:0]    retire_inst,
    input  logic [NUM_HARTS-1:0]       int_pending,
    input  logic [NUM_HARTS-1:0]       waive,
    input  logic                       err_clear,
    output logic                       err_valid,
    output logic [1:0]                 err_code,
    output logic [HART_W-1:0]          err_hart,
    output logic                       err_multi,
    output logic [NUM_HARTS-1:0]       err_sticky,
    output logic [CNT_W*NUM_HARTS-1:0] wfi_entries
);

    localparam int CW = $clog2(SKIP_CNT + 1);
    localparam int WW = $clog2(WAKE_CNT + 1);
    localparam logic [CW-1:0] CNT_LAST  = CW'(SKIP_CNT - 1);
    localparam logic [WW-1:0] WCNT_LAST = WW'(WAKE_CNT - 1);

    localparam logic [1:0] ERR_SPURIOUS   = 2'd0;
    localparam logic [1:0] ERR_TIMEOUT    = 2'd1;
    localparam logic [1:0] ERR_PEND_ENTRY = 2'd2;
    localparam logic [1:0] ERR_NO_WAKE    = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        ASLEEP = 2'd2
    } state_t;

    state_t               state_q   [NUM_HARTS];
    state_t               state_d   [NUM_HARTS];
    logic [CW-1:0]        cnt_q     [NUM_HARTS];
    logic [CW-1:0]        cnt_d     [NUM_HARTS];
    logic [WW-1:0]        wcnt_q    [NUM_HARTS];
    logic [WW-1:0]        wcnt_d    [NUM_HARTS];
    logic [CNT_W-1:0]     entries_q [NUM_HARTS];
    logic [CNT_W-1:0]     entries_d [NUM_HARTS];
    logic [1:0]           code_vec  [NUM_HARTS];
    logic [NUM_HARTS-1:0] woke_q;
    logic [NUM_HARTS-1:0] woke_d;
    logic [NUM_HARTS-1:0] wfi_q;
    logic [NUM_HARTS-1:0] err_vec;
    logic [NUM_HARTS-1:0] retire_wfi;
    logic [NUM_HARTS-1:0] retire_other;
    logic [1:0]           code_sel;
    logic [HART_W-1:0]    hart_sel;
    logic                 multi_now;

    // Classify each hart's retire strobe as a WFI or some other instruction
    always_comb begin
        for (int h = 0; h < NUM_HARTS; h++) begin
            retire_wfi[h]   = retire_valid[h] && (retire_inst[32*h +: 32] == WFI_OPCODE);
            retire_other[h] = retire_valid[h] && (retire_inst[32*h +: 32] != WFI_OPCODE);
        end
    end

    // Per-hart protocol tracker: next state, counters and violation detection
    always_comb begin
        for (int h = 0; h < NUM_HARTS; h++) begin
            state_d[h]   = state_q[h];
            cnt_d[h]     = cnt_q[h];
            wcnt_d[h]    = wcnt_q[h];
            woke_d[h]    = woke_q[h];
            entries_d[h] = entries_q[h];
            err_vec[h]   = 1'b0;
            code_vec[h]  = ERR_SPURIOUS;
            case (state_q[h])
                IDLE: begin
                    if (wfi[h] && !wfi_q[h]) begin
                        err_vec[h]  = 1'b1;
                        code_vec[h] = ERR_SPURIOUS;
                    end else if (retire_wfi[h]) begin
                        state_d[h] = ARMED;
                        cnt_d[h]   = '0;
                    end
                end
                ARMED: begin
                    if (wfi[h] && int_pending[h]) begin
                        err_vec[h]  = 1'b1;
                        code_vec[h] = ERR_PEND_ENTRY;
                        state_d[h]  = IDLE;
                    end else if (wfi[h]) begin
                        if (entries_q[h] != '1) begin
                            entries_d[h] = entries_q[h] + 1'b1;
                        end
                        state_d[h] = ASLEEP;
                        wcnt_d[h]  = '0;
                        woke_d[h]  = 1'b0;
                    end else if (int_pending[h] || waive[h]) begin
                        state_d[h] = IDLE;
                    end else if (retire_other[h]) begin
                        state_d[h] = IDLE;
                    end else if (retire_wfi[h]) begin
                        cnt_d[h] = '0;
                    end else if (cnt_q[h] == CNT_LAST) begin
                        err_vec[h]  = 1'b1;
                        code_vec[h] = ERR_TIMEOUT;
                        state_d[h]  = IDLE;
                    end else begin
                        cnt_d[h] = cnt_q[h] + 1'b1;
                    end
                end
                ASLEEP: begin
                    if (!wfi[h]) begin
                        state_d[h] = IDLE;
                        wcnt_d[h]  = '0;
                        woke_d[h]  = 1'b0;
                    end else if (int_pending[h]) begin
                        if (wcnt_q[h] != WCNT_LAST) begin
                            wcnt_d[h] = wcnt_q[h] + 1'b1;
                        end else if (!woke_q[h]) begin
                            err_vec[h]  = 1'b1;
                            code_vec[h] = ERR_NO_WAKE;
                            woke_d[h]   = 1'b1;
                        end
                    end else begin
                        wcnt_d[h] = '0;
                    end
                end
                default: begin
                    state_d[h] = IDLE;
                end
            endcase
        end
    end

    // Lowest-index erring hart owns the report; flag when more than one erred
    always_comb begin
        code_sel  = ERR_SPURIOUS;
        hart_sel  = '0;
        multi_now = |(err_vec & (err_vec - NUM_HARTS'(1)));
        for (int h = NUM_HARTS - 1; h >= 0; h--) begin
            if (err_vec[h]) begin
                code_sel = code_vec[h];
                hart_sel = HART_W'(h);
            end
        end
    end

    // Per-hart state registers; wfi_q resets high so a held wfi is not spurious
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int h = 0; h < NUM_HARTS; h++) begin
                state_q[h]   <= IDLE;
                cnt_q[h]     <= '0;
                wcnt_q[h]    <= '0;
                entries_q[h] <= '0;
            end
            woke_q <= '0;
            wfi_q  <= '1;
        end else begin
            for (int h = 0; h < NUM_HARTS; h++) begin
                state_q[h]   <= state_d[h];
                cnt_q[h]     <= cnt_d[h];
                wcnt_q[h]    <= wcnt_d[h];
                entries_q[h] <= entries_d[h];
            end
            woke_q <= woke_d;
            wfi_q  <= wfi;
        end
    end

    // Registered error reporting; a fresh error beats a simultaneous clear
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            err_valid  <= 1'b0;
            err_code   <= '0;
            err_hart   <= '0;
            err_multi  <= 1'b0;
            err_sticky <= '0;
        end else begin
            err_valid  <= |err_vec;
            err_code   <= code_sel;
            err_hart   <= hart_sel;
            err_multi  <= (err_clear ? 1'b0 : err_multi) | multi_now;
            err_sticky <= (err_clear ? '0 : err_sticky) | err_vec;
        end
    end

    for (genvar g = 0; g < NUM_HARTS; g++) begin : g_entries
        assign wfi_entries[CNT_W*g +: CNT_W] = entries_q[g];
    end

`ifdef WFI_PROTOCOL_MONITOR_FATAL_EN
`ifndef SYNTHESIS
    // Simulation-only: stop the run on the first reported violation
    always @(posedge clock) begin
        if (err_valid) begin
            $display("WFI error code=%0d hart=%0d", err_code, err_hart);
            $fatal(1, "WFI protocol violation");
        end
    end
`endif
`endif

endmodule

// File: tb/tb_wfi_protocol_monitor.sv
// tb_wfi_protocol_monitor
// Table-driven single-cycle vectors plus hand-written multi-cycle sequences.
// Expected error reports go into a scoreboard queue tagged with the cycle in
// which err_valid must appear; a negedge monitor pops and compares them.
module tb_wfi_protocol_monitor;

    localparam int          NUM_HARTS = 4;
    localparam int          SKIP_CNT  = 100;
    localparam int          WAKE_CNT  = 64;
    localparam int          CNT_W     = 16;
    localparam int          HART_W    = 2;
    localparam logic [31:0] WFI_OP    = 32'h10500073;
    localparam logic [31:0] NOP_OP    = 32'h00000013;

    logic                       clock;
    logic                       reset_n;
    logic [NUM_HARTS-1:0]       wfi;
    logic [NUM_HARTS-1:0]       retire_valid;
    logic [32*NUM_HARTS-1:0]    retire_inst;
    logic [NUM_HARTS-1:0]       int_pending;
    logic [NUM_HARTS-1:0]       waive;
    logic                       err_clear;
    logic                       err_valid;
    logic [1:0]                 err_code;
    logic [HART_W-1:0]          err_hart;
    logic                       err_multi;
    logic [NUM_HARTS-1:0]       err_sticky;
    logic [CNT_W*NUM_HARTS-1:0] wfi_entries;

    int n_checks = 0;
    int n_fails  = 0;
    int cyc      = 0;

    typedef struct {
        string                name;
        int                   due;
        logic [1:0]           code;
        logic [HART_W-1:0]    hart;
        logic                 multi;
        logic [NUM_HARTS-1:0] sticky;
    } exp_t;

    typedef struct {
        logic [NUM_HARTS-1:0] wfi;
        logic [NUM_HARTS-1:0] rv;
        logic [NUM_HARTS-1:0] is_wfi;
        logic [NUM_HARTS-1:0] pend;
        logic [NUM_HARTS-1:0] waive;
        logic                 clr;
        logic                 exp_valid;
        logic [1:0]           exp_code;
        logic [HART_W-1:0]    exp_hart;
        logic                 exp_multi;
        logic [NUM_HARTS-1:0] exp_sticky;
    } vec_t;

    exp_t sb[$];
    vec_t vecs[20];

    wfi_protocol_monitor #(
        .NUM_HARTS (NUM_HARTS),
        .SKIP_CNT  (SKIP_CNT),
        .WAKE_CNT  (WAKE_CNT),
        .CNT_W     (CNT_W),
        .WFI_OPCODE(WFI_OP)
    ) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .wfi         (wfi),
        .retire_valid(retire_valid),
        .retire_inst (retire_inst),
        .int_pending (int_pending),
        .waive       (waive),
        .err_clear   (err_clear),
        .err_valid   (err_valid),
        .err_code    (err_code),
        .err_hart    (err_hart),
        .err_multi   (err_multi),
        .err_sticky  (err_sticky),
        .wfi_entries (wfi_entries)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic expect_err(input string name, input int delay, input logic [1:0] code,
                              input logic [HART_W-1:0] hart, input logic multi,
                              input logic [NUM_HARTS-1:0] sticky);
        exp_t e;
        e.name   = name;
        e.due    = cyc + delay;
        e.code   = code;
        e.hart   = hart;
        e.multi  = multi;
        e.sticky = sticky;
        sb.push_back(e);
    endtask

    task automatic retire(input int h, input logic is_wfi);
        retire_valid[h]       = 1'b1;
        retire_inst[32*h +: 32] = is_wfi ? WFI_OP : NOP_OP;
    endtask

    task automatic clear_errors();
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
    endtask

    function automatic vec_t mk(input logic [3:0] w, input logic [3:0] rv, input logic [3:0] iw,
                                input logic [3:0] p, input logic [3:0] wv, input logic c,
                                input logic ev, input logic [1:0] ec, input logic [1:0] eh,
                                input logic em, input logic [3:0] es);
        vec_t v;
        v.wfi = w; v.rv = rv; v.is_wfi = iw; v.pend = p; v.waive = wv; v.clr = c;
        v.exp_valid = ev; v.exp_code = ec; v.exp_hart = eh; v.exp_multi = em; v.exp_sticky = es;
        return v;
    endfunction

    task automatic apply_stimulus(input int idx, input vec_t v);
        wfi          = v.wfi;
        retire_valid = v.rv;
        for (int h = 0; h < NUM_HARTS; h++) begin
            retire_inst[32*h +: 32] = v.is_wfi[h] ? WFI_OP : NOP_OP;
        end
        int_pending = v.pend;
        waive       = v.waive;
        err_clear   = v.clr;
        if (v.exp_valid) begin
            expect_err($sformatf("vec%0d", idx), 1, v.exp_code, v.exp_hart, v.exp_multi, v.exp_sticky);
        end
        tick();
        check_output($sformatf("vec%0d sticky", idx), 32'(err_sticky), 32'(v.exp_sticky));
        check_output($sformatf("vec%0d multi", idx), 32'(err_multi), 32'(v.exp_multi));
    endtask

    // Scoreboard monitor: compare due reports, flag any report nobody expected
    always @(negedge clock) begin
        exp_t e;
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            check_output({e.name, " err_valid"}, 32'(err_valid), 32'd1);
            check_output({e.name, " err_code"}, 32'(err_code), 32'(e.code));
            check_output({e.name, " err_hart"}, 32'(err_hart), 32'(e.hart));
            check_output({e.name, " err_multi"}, 32'(err_multi), 32'(e.multi));
            check_output({e.name, " err_sticky"}, 32'(err_sticky), 32'(e.sticky));
        end else if (err_valid) begin
            check_output("unexpected err_valid", 32'(err_valid), 32'd0);
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // wfi, rv, is_wfi, pend, waive, clr | valid, code, hart, multi, sticky
        vecs[0]  = mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 4'b0000);
        vecs[1]  = mk(4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd0, 2'd0, 1'b0, 4'b0001);
        vecs[2]  = mk(4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 4'b0001);
        vecs[3]  = mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 4'b0001);
        vecs[4]  = mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 4'b0000);
        vecs[5]  = mk(4'b0101, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd0, 2'd0, 1'b1, 4'b0101);
        vecs[6]  = mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 4'b0000);
        vecs[7]  = mk(4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b1, 2'd0, 2'd2, 1'b0, 4'b0100);
        vecs[8]  = mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 4'b0000);
        vecs[9]  = mk(4'b0000, 4'b0010, 4'b0010, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 4'b0000);
        vecs[10] = mk(4'b0010, 4'b0000, 4'b0000, 4'b0010, 4'b0000, 1'b0, 1'b1, 2'd2, 2'd1, 1'b0, 4'b0010);
        vecs[11] = mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 4'b0000);
        vecs[12] = mk(4'b0000, 4'b1000, 4'b1000, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 4'b0000);
        vecs[13] = mk(4'b0000, 4'b1000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 4'b0000);
        vecs[14] = mk(4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd0, 2'd3, 1'b0, 4'b1000);
        vecs[15] = mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 4'b0000);
        vecs[16] = mk(4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 4'b0000);
        vecs[17] = mk(4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0000, 1'b0, 1'b0, 2'd0, 2'd0, 1'b0, 4'b0000);
        vecs[18] = mk(4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b0, 1'b1, 2'd0, 2'd0, 1'b0, 4'b0001);
        vecs[19] = mk(4'b0000, 4'b0000, 4'b0000, 4'b0000, 4'b0000, 1'b1, 1'b0, 2'd0, 2'd0, 1'b0, 4'b0000);

        reset_n      = 1'b0;
        wfi          = '0;
        retire_valid = '0;
        retire_inst  = '0;
        int_pending  = '0;
        waive        = '0;
        err_clear    = 1'b0;
        #1;
        check_output("reset err_valid", 32'(err_valid), 32'd0);
        check_output("reset err_sticky", 32'(err_sticky), 32'd0);
        repeat (3) tick();
        reset_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            apply_stimulus(i, vecs[i]);
        end

        // Hart 2: legal entry ten cycles after retire; retire while asleep is ignored
        retire(2, 1'b1);
        tick();
        retire_valid = '0;
        repeat (9) tick();
        wfi[2] = 1'b1;
        tick();
        retire(2, 1'b0);
        tick();
        retire_valid = '0;
        check_output("hart2 entries", 32'(wfi_entries[2*CNT_W +: CNT_W]), 32'd1);
        wfi[2] = 1'b0;
        tick();

        // Hart 1: timeout exactly SKIP_CNT cycles after retire
        retire(1, 1'b1);
        expect_err("timeout", SKIP_CNT + 1, 2'd1, 2'd1, 1'b0, 4'b0010);
        tick();
        retire_valid = '0;
        repeat (SKIP_CNT + 3) tick();
        clear_errors();

        // Hart 1: waive at cycle 5 cancels the timeout silently
        retire(1, 1'b1);
        tick();
        retire_valid = '0;
        repeat (4) tick();
        waive[1] = 1'b1;
        tick();
        waive[1] = 1'b0;
        repeat (SKIP_CNT + 3) tick();
        check_output("waive sticky", 32'(err_sticky), 32'd0);

        // Hart 1: wfi sampled in the last allowed cycle is a legal entry
        retire(1, 1'b1);
        tick();
        retire_valid = '0;
        repeat (SKIP_CNT - 1) tick();
        wfi[1] = 1'b1;
        tick();
        check_output("boundary entries", 32'(wfi_entries[1*CNT_W +: CNT_W]), 32'd1);
        wfi[1] = 1'b0;
        tick();

        // Hart 1: one cycle late times out, then the rise itself is spurious
        retire(1, 1'b1);
        expect_err("late timeout", SKIP_CNT + 1, 2'd1, 2'd1, 1'b0, 4'b0010);
        expect_err("late spurious", SKIP_CNT + 2, 2'd0, 2'd1, 1'b0, 4'b0010);
        tick();
        retire_valid = '0;
        repeat (SKIP_CNT) tick();
        wfi[1] = 1'b1;
        tick();
        wfi[1] = 1'b0;
        tick();
        check_output("late entries", 32'(wfi_entries[1*CNT_W +: CNT_W]), 32'd1);
        clear_errors();

        // Hart 3: wcnt clears when pending drops, then a single NO_WAKE
        retire(3, 1'b1);
        tick();
        retire_valid = '0;
        wfi[3] = 1'b1;
        tick();
        int_pending[3] = 1'b1;
        repeat (WAKE_CNT - 1) tick();
        int_pending[3] = 1'b0;
        tick();
        int_pending[3] = 1'b1;
        expect_err("no wake", WAKE_CNT, 2'd3, 2'd3, 1'b0, 4'b1000);
        repeat (3 * WAKE_CNT) tick();
        int_pending[3] = 1'b0;
        wfi[3] = 1'b0;
        tick();
        check_output("hart3 entries", 32'(wfi_entries[3*CNT_W +: CNT_W]), 32'd1);
        clear_errors();

        // Reset while hart 1 sleeps: everything clears, held wfi stays quiet
        retire(1, 1'b1);
        tick();
        retire_valid = '0;
        wfi[1] = 1'b1;
        tick();
        check_output("hart1 entries", 32'(wfi_entries[1*CNT_W +: CNT_W]), 32'd2);
        wfi[0] = 1'b1;
        wfi[2] = 1'b1;
        expect_err("spurious pair", 1, 2'd0, 2'd0, 1'b1, 4'b0101);
        tick();
        tick();
        reset_n = 1'b0;
        #2;
        check_output("midreset err_valid", 32'(err_valid), 32'd0);
        check_output("midreset err_sticky", 32'(err_sticky), 32'd0);
        check_output("midreset err_multi", 32'(err_multi), 32'd0);
        check_output("midreset entries lo", wfi_entries[31:0], 32'd0);
        check_output("midreset entries hi", wfi_entries[63:32], 32'd0);
        tick();
        tick();
        reset_n = 1'b1;
        repeat (4) tick();
        check_output("post reset sticky", 32'(err_sticky), 32'd0);
        wfi = '0;
        tick();
        wfi[1] = 1'b1;
        expect_err("spurious after reset", 1, 2'd0, 2'd1, 1'b0, 4'b0010);
        tick();
        tick();
        wfi = '0;
        repeat (3) tick();

        check_output("scoreboard drained", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
